branch_resolve_bht: RTL and testbench

Branch resolution and prediction unit for the ID stage of the 5-stage RV32 pipeline. It evaluates all six RV32I conditional branches (BEQ, BNE, BLT, BGE, BLTU, BGEU) on the forwarded operands. It holds a parametrised branch history table (BHT) of 2-bit saturating counters, which IF reads to predict the next fetch. It flags mispredictions for the hazard/flush logic and keeps saturating statistics counters.

---
 rtl/branch_resolve_bht_if.sv | 35 +++
 rtl/branch_resolve_bht.sv | 134 +++++++++++++
 tb/tb_branch_resolve_bht.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_bht_if.sv
// Branch resolve / prediction bus between the IF/ID pipeline and the
// branch_resolve_bht unit.
//   if_pc, if_pred_taken            : fetch-side BHT lookup
//   id_valid .. rs2Data             : ID-stage instruction and forwarded operands
//   Branch, mispredict, br_illegal  : combinational resolve results
// master = pipeline side, slave = branch unit side.
interface branch_resolve_bht_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            id_valid;
  logic            id_stall;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [XLEN-1:0] id_pc;
  logic            id_pred_taken;
  logic [XLEN-1:0] rs1Data;
  logic [XLEN-1:0] rs2Data;
  logic            Branch;
  logic            mispredict;
  logic            br_illegal;

  modport master (
    output if_pc, id_valid, id_stall, id_opcode, id_funct3, id_pc,
           id_pred_taken, rs1Data, rs2Data,
    input  if_pred_taken, Branch, mispredict, br_illegal
  );

  modport slave (
    input  if_pc, id_valid, id_stall, id_opcode, id_funct3, id_pc,
           id_pred_taken, rs1Data, rs2Data,
    output if_pred_taken, Branch, mispredict, br_illegal
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// Branch resolution and prediction unit for the ID stage.
// Resolves RV32I conditional branches on forwarded operands, holds a BHT of
// 2-bit saturating counters read combinationally by IF, flags mispredictions
// and keeps saturating statistics counters.
// Ports:
//   clk, rst_n      : clock (rising edge), async active-low reset
//   br_if (slave)   : IF lookup, ID resolve inputs and resolve results
//   stat_clr        : synchronous clear of both statistics counters
//   branch_cnt      : resolved branch count (saturating)
//   mispredict_cnt  : misprediction count (saturating)
module branch_resolve_bht #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH),
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_resolve_bht_if.slave br_if,
  input  logic                stat_clr,
  output logic [CNT_W-1:0]    branch_cnt,
  output logic [CNT_W-1:0]    mispredict_cnt
);

  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [1:0] BHT_INIT  = 2'b01;

  if (BHT_DEPTH < 2 || (BHT_DEPTH & (BHT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BHT_DEPTH must be a power of two and at least 2");
  end

  logic             is_branch;
  logic             f3_legal;
  logic             resolve;
  logic             upd_en;
  logic             eq;
  logic             lt;
  logic             ltu;
  logic             taken;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;
  logic [1:0]       cur_ctr;
  logic [1:0]       nxt_ctr;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_d;

  // PC bits outside the index field never affect the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{br_if.if_pc[1:0], br_if.id_pc[1:0],
                            br_if.if_pc[XLEN-1:IDX_W+2],
                            br_if.id_pc[XLEN-1:IDX_W+2]};

  assign if_idx = br_if.if_pc[IDX_W+1:2];
  assign id_idx = br_if.id_pc[IDX_W+1:2];

  // Resolve. Explicit comparators rather than an adder so that operands
  // summing to zero are not mistaken for equal.
  always_comb begin
    is_branch = (br_if.id_opcode == OP_BRANCH);
    f3_legal  = (br_if.id_funct3 != 3'd2) && (br_if.id_funct3 != 3'd3);
    resolve   = br_if.id_valid & is_branch & f3_legal;
    upd_en    = resolve & ~br_if.id_stall;

    eq  = (br_if.rs1Data == br_if.rs2Data);
    lt  = ($signed(br_if.rs1Data) < $signed(br_if.rs2Data));
    ltu = (br_if.rs1Data < br_if.rs2Data);

    taken = 1'b0;
    case (br_if.id_funct3)
      3'd0:    taken = eq;
      3'd1:    taken = ~eq;
      3'd4:    taken = lt;
      3'd5:    taken = ~lt;
      3'd6:    taken = ltu;
      3'd7:    taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  assign br_if.Branch        = resolve & taken;
  assign br_if.mispredict    = resolve & (taken != br_if.id_pred_taken);
  assign br_if.br_illegal    = br_if.id_valid & is_branch & ~f3_legal;
  // No write-to-read bypass: IF always sees the registered entry.
  assign br_if.if_pred_taken = bht_q[if_idx][1];

  // BHT next state: one saturating counter step at the ID index.
  always_comb begin
    cur_ctr = bht_q[id_idx];
    nxt_ctr = cur_ctr;
    if (taken) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
    end

    bht_d = bht_q;
    if (upd_en) bht_d[id_idx] = nxt_ctr;
  end

  // Statistics; clear wins over a coincident increment.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (stat_clr) begin
      branch_cnt_d     = '0;
      mispredict_cnt_d = '0;
    end else if (upd_en) begin
      if (~&branch_cnt_q) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (br_if.mispredict && ~&mispredict_cnt_q)
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_INIT;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      bht_q            <= bht_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht (BHT_DEPTH = 64, CNT_W = 4).
// Stimulus pushes the hand-computed response for each cycle into a queue;
// the monitor pops and compares on the falling edge.
module tb_branch_resolve_bht;

  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_ALU = 7'h33;

  typedef struct packed {
    int         id;
    logic       br;
    logic       mp;
    logic       ill;
    logic       pred;
    logic [3:0] bc;
    logic [3:0] mc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       stat_clr;
  logic [3:0] branch_cnt;
  logic [3:0] mispredict_cnt;

  int   checks   = 0;
  int   failures = 0;
  int   sid      = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  branch_resolve_bht_if #(.XLEN(32)) bus ();

  branch_resolve_bht #(
    .XLEN(32), .BHT_DEPTH(64), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .br_if(bus.slave),
    .stat_clr(stat_clr),
    .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int id, input string nm, input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL step%0d %s: got %0h expected %0h", id, nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.id, "Branch",         {3'b0, bus.Branch},        {3'b0, mon_e.br});
      chk(mon_e.id, "mispredict",     {3'b0, bus.mispredict},    {3'b0, mon_e.mp});
      chk(mon_e.id, "br_illegal",     {3'b0, bus.br_illegal},    {3'b0, mon_e.ill});
      chk(mon_e.id, "if_pred_taken",  {3'b0, bus.if_pred_taken}, {3'b0, mon_e.pred});
      chk(mon_e.id, "branch_cnt",     branch_cnt,                mon_e.bc);
      chk(mon_e.id, "mispredict_cnt", mispredict_cnt,            mon_e.mc);
    end
  end

  task automatic drive(input logic v, input logic st, input logic [6:0] op,
                       input logic [2:0] f3, input logic [31:0] ipc,
                       input logic pt, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] fpc,
                       input logic clr);
    bus.id_valid      = v;
    bus.id_stall      = st;
    bus.id_opcode     = op;
    bus.id_funct3     = f3;
    bus.id_pc         = ipc;
    bus.id_pred_taken = pt;
    bus.rs1Data       = a;
    bus.rs2Data       = b;
    bus.if_pc         = fpc;
    stat_clr          = clr;
  endtask

  task automatic push(input logic eb, input logic em, input logic ei,
                      input logic ep, input logic [3:0] ebc,
                      input logic [3:0] emc);
    exp_t e;
    sid++;
    e.id = sid; e.br = eb; e.mp = em; e.ill = ei; e.pred = ep;
    e.bc = ebc; e.mc = emc;
    exp_q.push_back(e);
  endtask

  // One cycle: inputs applied just after a rising edge, expected outputs
  // reflect state after that edge; the update lands on the next edge.
  task automatic step(input logic v, input logic st, input logic [6:0] op,
                      input logic [2:0] f3, input logic [31:0] ipc,
                      input logic pt, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] fpc,
                      input logic clr, input logic eb, input logic em,
                      input logic ei, input logic ep, input logic [3:0] ebc,
                      input logic [3:0] emc);
    @(posedge clk);
    #1;
    drive(v, st, op, f3, ipc, pt, a, b, fpc, clr);
    push(eb, em, ei, ep, ebc, emc);
  endtask

  task automatic idle(input logic [31:0] fpc, input logic ep,
                      input logic [3:0] ebc, input logic [3:0] emc);
    step(1'b0, 1'b0, 7'h00, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, fpc, 1'b0,
         1'b0, 1'b0, 1'b0, ep, ebc, emc);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 7'h00, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h40, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    idle(32'h40, 1'b0, 4'd0, 4'd0);

    // compare coverage, stalled so the BHT and counters stay untouched
    //   v     st    op     f3    id_pc  pt    rs1            rs2            if_pc  clr   br    mp    ill   pred  bc    mc
    step(1'b1, 1'b1, OP_BR, 3'd4, 32'h80, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, OP_BR, 3'd6, 32'h80, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, OP_BR, 3'd0, 32'h80, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, OP_BR, 3'd0, 32'h80, 1'b0, 32'h5,         32'hFFFF_FFFB, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, OP_BR, 3'd1, 32'h80, 1'b0, 32'h5,         32'hFFFF_FFFB, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, OP_BR, 3'd5, 32'h80, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, OP_BR, 3'd7, 32'h80, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, OP_BR, 3'd5, 32'h80, 1'b1, 32'h7,         32'h7,         32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // saturate up at 0x40: 01 -> 10 -> 11 -> 11
    step(1'b1, 1'b0, OP_BR, 3'd0, 32'h40, 1'b0, 32'h0, 32'h0, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, OP_BR, 3'd0, 32'h40, 1'b1, 32'h0, 32'h0, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1);
    step(1'b1, 1'b0, OP_BR, 3'd0, 32'h40, 1'b1, 32'h0, 32'h0, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1);
    idle(32'h40, 1'b1, 4'd3, 4'd1);

    // not-taken run with a stalled mispredict in the middle: 11 -> 10 -> (stall) -> 01 -> 00 -> 00
    step(1'b1, 1'b0, OP_BR, 3'd1, 32'h40, 1'b1, 32'h3, 32'h3, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd1);
    step(1'b1, 1'b1, OP_BR, 3'd1, 32'h40, 1'b1, 32'h3, 32'h3, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd2);
    step(1'b1, 1'b0, OP_BR, 3'd1, 32'h40, 1'b1, 32'h3, 32'h3, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd2);
    step(1'b1, 1'b0, OP_BR, 3'd1, 32'h40, 1'b0, 32'h3, 32'h3, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd3);
    step(1'b1, 1'b0, OP_BR, 3'd1, 32'h40, 1'b0, 32'h3, 32'h3, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd3);
    // one taken from 00 must land on 01 (pred 0), proving no wrap at the bottom
    step(1'b1, 1'b0, OP_BR, 3'd0, 32'h40, 1'b0, 32'h0, 32'h0, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd3);
    idle(32'h40, 1'b0, 4'd8, 4'd4);

    // illegal funct3, invalid, non-branch: no outputs, no updates
    step(1'b1, 1'b0, OP_BR,  3'd2, 32'h40, 1'b1, 32'h0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 4'd4);
    step(1'b1, 1'b0, OP_BR,  3'd3, 32'h40, 1'b1, 32'h0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 4'd4);
    step(1'b0, 1'b0, OP_BR,  3'd0, 32'h40, 1'b1, 32'h0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd4);
    step(1'b1, 1'b0, OP_ALU, 3'd0, 32'h40, 1'b1, 32'h0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd4);
    idle(32'h40, 1'b0, 4'd8, 4'd4);

    // aliasing: write via 0x100, read index 0 via 0x0 in the same cycle (old value) and after
    step(1'b1, 1'b0, OP_BR, 3'd0, 32'h100, 1'b0, 32'h9, 32'h9, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 4'd4);
    idle(32'h0, 1'b1, 4'd9, 4'd5);
    idle(32'h2, 1'b1, 4'd9, 4'd5);

    // 20 taken mispredicted branches at 0x204 (index 1): both counters pin at 4'hF
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, OP_BR, 3'd0, 32'h204, 1'b0, 32'h0, 32'h0, 32'h204, 1'b0,
           1'b1, 1'b1, 1'b0, (i != 0),
           4'((9 + i) > 15 ? 15 : 9 + i), 4'((5 + i) > 15 ? 15 : 5 + i));
    end
    idle(32'h204, 1'b1, 4'hF, 4'hF);

    // stat_clr coincident with a resolve
    step(1'b1, 1'b0, OP_BR, 3'd0, 32'h204, 1'b1, 32'h0, 32'h0, 32'h204, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF);
    idle(32'h204, 1'b1, 4'd0, 4'd0);
    step(1'b1, 1'b0, OP_BR, 3'd0, 32'h204, 1'b0, 32'h0, 32'h0, 32'h204, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    idle(32'h204, 1'b1, 4'd1, 4'd1);

    // asynchronous reset between clock edges
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 7'h00, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h204, 1'b0);
    #2 rst_n = 1'b0;
    #1 push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(32'h0, 1'b0, 4'd0, 4'd0);
    rst_n = 1'b1;
    idle(32'h0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, OP_BR, 3'd0, 32'h0, 1'b0, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(32'h0, 1'b1, 4'd1, 4'd1);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
